// File: rtl/number_digitizer.sv
// number_digitizer: sequential binary-to-decimal converter (double dabble) with
// leading-zero blanking, feeding the seven-segment digit renderer.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - synchronous, active-high reset
//   start   - request conversion of number; only honoured while idle
//   number  - unsigned binary input, captured on the accepting edge
//   busy    - high while a conversion is in progress (registered)
//   valid   - one-cycle pulse when digits has just been updated (registered)
//   digits  - packed digit array, digit i at [4i+:4], i=0 most significant;
//             value 10 marks a blanked position
module number_digitizer #(
  parameter int unsigned NUMBER_WIDTH = 8,
  // ceil(NUMBER_WIDTH * log10(2)) in integer arithmetic (log10(2) ~ 0.30103)
  localparam int unsigned DIGITS_COUNT = (NUMBER_WIDTH * 30103 + 99999) / 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUMBER_WIDTH-1:0]   number,
  output logic                      busy,
  output logic                      valid,
  output logic [4*DIGITS_COUNT-1:0] digits
);

  localparam int unsigned COUNT_W = $clog2(NUMBER_WIDTH + 1);
  localparam int unsigned BCD_W   = 4 * DIGITS_COUNT;

  typedef logic [3:0] digit_t;
  localparam digit_t EMPTY_DIGIT = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  // Idle display pattern: everything blank except the least significant "0"
  function automatic logic [BCD_W-1:0] reset_pattern();
    logic [BCD_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 1 < DIGITS_COUNT; i++) begin
      r[4*i +: 4] = EMPTY_DIGIT;
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0] RESET_DIGITS = reset_pattern();

  state_t                    state_q, state_d;
  logic [NUMBER_WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic                      busy_d;
  logic                      valid_d;
  logic [BCD_W-1:0]          digits_d;
  logic [BCD_W-1:0]          adj;
  logic                      lead;
  digit_t                    nib;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      digits  <= RESET_DIGITS;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      busy    <= busy_d;
      valid   <= valid_d;
      digits  <= digits_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    digits_d = digits;
    valid_d  = 1'b0;
    adj      = '0;
    lead     = 1'b1;
    nib      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = number;
          bcd_d   = '0;
          count_d = COUNT_W'(NUMBER_WIDTH);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Add-3 correction per nibble, no carry between nibbles, then shift
        adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS_COUNT; i++) begin
          if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        count_d = count_q - COUNT_W'(1);
        if (count_q == COUNT_W'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Reverse nibble order and blank leading zeros; last digit always shown
        for (int unsigned i = 0; i < DIGITS_COUNT; i++) begin
          nib = bcd_q[4*(DIGITS_COUNT-1-i) +: 4];
          if (lead && (nib == 4'd0) && (i != DIGITS_COUNT - 1)) begin
            digits_d[4*i +: 4] = EMPTY_DIGIT;
          end else begin
            digits_d[4*i +: 4] = nib;
            lead = 1'b0;
          end
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_number_digitizer.sv
// tb_number_digitizer: scoreboard bench for number_digitizer at widths 8 and 10.
// Expected digit words are pushed when a conversion is started and popped when
// the matching valid pulse appears.
module tb_number_digitizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start10;
  logic [7:0]  number8;
  logic [9:0]  number10;
  logic        busy8, valid8, busy10, valid10;
  logic [11:0] digits8;
  logic [15:0] digits10;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q8[$];
  logic [15:0] exp_q10[$];

  always #5 clk = ~clk;

  number_digitizer #(.NUMBER_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .number(number8),
    .busy(busy8), .valid(valid8), .digits(digits8)
  );

  number_digitizer #(.NUMBER_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .number(number10),
    .busy(busy10), .valid(valid10), .digits(digits10)
  );

  // Pack digits given most significant first (index 0 first)
  function automatic logic [11:0] p3(input int a, input int b, input int c);
    return {4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [15:0] p4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Reference: divide/modulo per decimal position, then leading-zero blanking
  function automatic logic [15:0] ref_dig(input int v, input int dc);
    logic [15:0] r;
    bit lead;
    int p, d;
    r = '0;
    lead = 1'b1;
    for (int i = 0; i < dc; i++) begin
      p = 1;
      for (int k = 0; k < dc - 1 - i; k++) p = p * 10;
      d = (v / p) % 10;
      if (lead && d == 0 && i != dc - 1) r[4*i +: 4] = 4'd10;
      else begin
        r[4*i +: 4] = 4'(d);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Drive one width-8 conversion from the current negedge and observe it.
  // inject_j >= 0 pulses start (number 99) at that cycle of the conversion.
  // chain=1 returns on the valid negedge so the caller can start back-to-back.
  task automatic conv8(input int num, input int inject_j, input bit chain,
                       output int lat, output int bcnt, output logic [11:0] dig,
                       output bit stable, output bit tmo, output bit idle_after);
    logic [11:0] prev;
    int j;
    lat = 0; bcnt = 0; stable = 1'b1; tmo = 1'b0; idle_after = 1'b1; dig = 'x;
    start8 = 1'b1;
    number8 = 8'(num);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    number8 = 8'($urandom);
    prev = digits8;
    j = 0;
    while (valid8 !== 1'b1 && j < 40) begin
      if (digits8 !== prev) stable = 1'b0;
      if (busy8 === 1'b1) bcnt++;
      if (j == inject_j) begin
        start8 = 1'b1;
        number8 = 8'd99;
      end else start8 = 1'b0;
      j++;
      @(negedge clk);
    end
    start8 = 1'b0;
    if (valid8 !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    lat = j;
    dig = digits8;
    if (busy8 !== 1'b0) idle_after = 1'b0;
    if (!chain) begin
      @(negedge clk);
      if (valid8 !== 1'b0 || digits8 !== dig) idle_after = 1'b0;
    end
  endtask

  task automatic conv10(input int num, output int lat, output int bcnt,
                        output logic [15:0] dig, output bit stable, output bit tmo);
    logic [15:0] prev;
    int j;
    lat = 0; bcnt = 0; stable = 1'b1; tmo = 1'b0; dig = 'x;
    start10 = 1'b1;
    number10 = 10'(num);
    @(posedge clk);
    @(negedge clk);
    start10 = 1'b0;
    number10 = 10'($urandom);
    prev = digits10;
    j = 0;
    while (valid10 !== 1'b1 && j < 40) begin
      if (digits10 !== prev) stable = 1'b0;
      if (busy10 === 1'b1) bcnt++;
      j++;
      @(negedge clk);
    end
    if (valid10 !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    lat = j;
    dig = digits10;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat, bcnt;
    logic [11:0] dig, exp;
    bit stable, tmo, idle;
    rst = 1'b1; start8 = 1'b1; start10 = 1'b1; number8 = 8'd77; number10 = 10'd77;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (digits8 !== p3(10, 10, 0)) begin
      n_err++; $display("FAIL reset_digits8 got %h want %h", digits8, p3(10, 10, 0));
    end
    n_cmp++;
    if (digits10 !== p4(10, 10, 10, 0)) begin
      n_err++; $display("FAIL reset_digits10 got %h want %h", digits10, p4(10, 10, 10, 0));
    end
    n_cmp++;
    if ({busy8, valid8, busy10, valid10} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {busy8, valid8, busy10, valid10});
    end
    start8 = 1'b0; start10 = 1'b0; rst = 1'b0;
    @(negedge clk);
    exp_q8.push_back(p3(10, 10, 0));
    conv8(0, -1, 1'b0, lat, bcnt, dig, stable, tmo, idle);
    exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
    n_cmp++;
    if (tmo !== 1'b0 || lat !== 9) begin
      n_err++; $display("FAIL zero_latency got %0d (timeout %0d) want 9", lat, tmo);
    end
    n_cmp++;
    if (dig !== exp) begin
      n_err++; $display("FAIL zero_digits got %h want %h", dig, exp);
    end
  endtask

  task automatic test_values();
    int vals[4];
    int lat, bcnt;
    logic [11:0] dig, exp;
    bit stable, tmo, idle;
    vals = '{255, 7, 100, 40};
    exp_q8.push_back(p3(2, 5, 5));
    exp_q8.push_back(p3(10, 10, 7));
    exp_q8.push_back(p3(1, 0, 0));
    exp_q8.push_back(p3(10, 4, 0));
    foreach (vals[k]) begin
      conv8(vals[k], -1, 1'b0, lat, bcnt, dig, stable, tmo, idle);
      exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
      n_cmp++;
      if (dig !== exp) begin
        n_err++; $display("FAIL value_%0d digits got %h want %h", vals[k], dig, exp);
      end
      n_cmp++;
      if (tmo !== 1'b0 || lat !== 9 || bcnt !== 9) begin
        n_err++; $display("FAIL value_%0d timing got lat %0d busy %0d tmo %0d want 9/9/0", vals[k], lat, bcnt, tmo);
      end
      n_cmp++;
      if (stable !== 1'b1 || idle !== 1'b1) begin
        n_err++; $display("FAIL value_%0d pulse got stable %0d idle %0d want 1/1", vals[k], stable, idle);
      end
    end
  endtask

  task automatic test_width10();
    int vals[2];
    int lat, bcnt;
    logic [15:0] dig, exp;
    bit stable, tmo;
    vals = '{1023, 5};
    exp_q10.push_back(p4(1, 0, 2, 3));
    exp_q10.push_back(p4(10, 10, 10, 5));
    foreach (vals[k]) begin
      conv10(vals[k], lat, bcnt, dig, stable, tmo);
      exp = (exp_q10.size() > 0) ? exp_q10.pop_front() : 'x;
      n_cmp++;
      if (dig !== exp) begin
        n_err++; $display("FAIL w10_%0d digits got %h want %h", vals[k], dig, exp);
      end
      n_cmp++;
      if (tmo !== 1'b0 || lat !== 11 || bcnt !== 11 || stable !== 1'b1) begin
        n_err++; $display("FAIL w10_%0d timing got lat %0d busy %0d stable %0d want 11/11/1", vals[k], lat, bcnt, stable);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [11:0] dig, exp;
    bit stable, tmo, idle;
    exp_q8.push_back(p3(2, 5, 5));
    conv8(255, 3, 1'b1, lat, bcnt, dig, stable, tmo, idle);
    exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
    n_cmp++;
    if (dig !== exp || tmo !== 1'b0 || lat !== 9) begin
      n_err++; $display("FAIL ignore_start got %h lat %0d want %h lat 9", dig, lat, exp);
    end
    exp_q8.push_back(p3(10, 9, 9));
    conv8(99, -1, 1'b0, lat, bcnt, dig, stable, tmo, idle);
    exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
    n_cmp++;
    if (dig !== exp || tmo !== 1'b0 || lat !== 9) begin
      n_err++; $display("FAIL b2b_start got %h lat %0d want %h lat 9", dig, lat, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [11:0] dig, exp;
    bit stable, tmo, idle, saw_valid;
    start8 = 1'b1;
    number8 = 8'd123;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (digits8 !== p3(10, 10, 0) || busy8 !== 1'b0 || valid8 !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got digits %h busy %b valid %b want %h 0 0", digits8, busy8, valid8, p3(10, 10, 0));
    end
    rst = 1'b0;
    start8 = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (valid8 !== 1'b0 || busy8 !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_quiet got activity %0d want 0", saw_valid);
    end
    exp_q8.push_back(p3(1, 2, 3));
    conv8(123, -1, 1'b0, lat, bcnt, dig, stable, tmo, idle);
    exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
    n_cmp++;
    if (dig !== exp || tmo !== 1'b0 || lat !== 9) begin
      n_err++; $display("FAIL after_reset got %h lat %0d want %h lat 9", dig, lat, exp);
    end
  endtask

  task automatic test_exhaustive();
    int lat, bcnt;
    logic [11:0] dig, exp;
    logic [15:0] r;
    bit stable, tmo, idle;
    for (int v = 0; v < 256; v++) begin
      r = ref_dig(v, 3);
      exp_q8.push_back(r[11:0]);
      conv8(v, -1, (v != 255), lat, bcnt, dig, stable, tmo, idle);
      exp = (exp_q8.size() > 0) ? exp_q8.pop_front() : 'x;
      n_cmp++;
      if (dig !== exp || tmo !== 1'b0 || lat !== 9 || stable !== 1'b1) begin
        n_err++; $display("FAIL exh_%0d got %h lat %0d stable %0d want %h lat 9 stable 1", v, dig, lat, stable, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_width10();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
